// File: rtl/config_readback_tx_if.sv
// config_readback_tx_if: RAM read port and UART transmit handshake of the readback transmitter
interface config_readback_tx_if #(parameter int ADDR_W = 5);
  logic [2:0] mem_ch;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_rd_en;
  logic [7:0] mem_data;
  logic [7:0] tx_data;
  logic tx_start;
  logic tx_busy;
  modport master (output mem_ch, mem_addr, mem_rd_en, tx_data, tx_start, input mem_data, tx_busy);
  modport slave (input mem_ch, mem_addr, mem_rd_en, tx_data, tx_start, output mem_data, tx_busy);
endinterface

// File: rtl/config_readback_tx.sv
// config_readback_tx: serializes the configuration snapshot and channel delay RAMs back to the host UART
module config_readback_tx #(
  parameter logic [2:0] HANDSHAKE = 3'b110,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic abort,
  input logic [7:0] channel_select,
  input logic [4:0] aline_select,
  input logic [31:0] pulse_shape,
  config_readback_tx_if.master bus,
  output logic busy,
  output logic done
);
  localparam int IW = ADDR_W + 4;
  localparam int KW = ADDR_W + 3;
  localparam logic [IW-1:0] LAST = IW'(6 + 8 * (2 ** ADDR_W) - 1);
  typedef enum logic [2:0] {IDLE, LOAD, RD_WAIT, SEND, TX_WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [KW-1:0] k;
  logic [7:0] cs_q, cs_d, tx_data_q, tx_data_d, hdr;
  logic [4:0] al_q, al_d;
  logic [31:0] ps_q, ps_d;
  logic [1:0] lat_q, lat_d;
  logic tx_start_q, tx_start_d, hdr_phase, last, lat_hit, rd;
  assign hdr_phase = idx_q < IW'(6);
  assign last = idx_q == LAST;
  assign lat_hit = lat_q == 2'(RD_LAT - 1);
  assign rd = state_q == LOAD && !hdr_phase;
  assign k = idx_q[KW-1:0] - KW'(6);
  assign hdr = idx_q[2:0] == 3'd0 ? {HANDSHAKE, cs_q[7:3]} :
               idx_q[2:0] == 3'd1 ? {cs_q[2:0], al_q} :
               idx_q[2:0] == 3'd2 ? ps_q[31:24] :
               idx_q[2:0] == 3'd3 ? ps_q[23:16] :
               idx_q[2:0] == 3'd4 ? ps_q[15:8] : ps_q[7:0];
  assign {bus.mem_ch, bus.mem_addr} = rd ? k : '0;
  assign bus.mem_rd_en = rd;
  assign bus.tx_data = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign busy = state_q != IDLE && state_q != DONE;
  assign done = state_q == DONE;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cs_d = cs_q;
    al_d = al_q;
    ps_d = ps_q;
    tx_data_d = tx_data_q;
    lat_d = lat_q;
    tx_start_d = 1'b0;
    case (state_q)
      IDLE: if (start && !abort) begin
        state_d = LOAD;
        idx_d = '0;
        cs_d = channel_select;
        al_d = aline_select;
        ps_d = pulse_shape;
      end
      LOAD: begin
        state_d = hdr_phase ? SEND : RD_WAIT;
        tx_data_d = hdr_phase ? hdr : tx_data_q;
        lat_d = '0;
      end
      RD_WAIT: begin
        state_d = lat_hit ? SEND : RD_WAIT;
        tx_data_d = lat_hit ? bus.mem_data : tx_data_q;
        lat_d = lat_q + 2'd1;
      end
      SEND: begin
        state_d = bus.tx_busy ? SEND : TX_WAIT;
        tx_start_d = !bus.tx_busy;
      end
      // the UART only raises tx_busy after seeing tx_start, so the strobe cycle itself is skipped
      TX_WAIT: if (!tx_start_q && !bus.tx_busy) begin
        state_d = last ? DONE : LOAD;
        idx_d = last ? idx_q : idx_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      tx_start_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      cs_q <= '0;
      al_q <= '0;
      ps_q <= '0;
      tx_data_q <= '0;
      lat_q <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cs_q <= cs_d;
      al_q <= al_d;
      ps_q <= ps_d;
      tx_data_q <= tx_data_d;
      lat_q <= lat_d;
      tx_start_q <= tx_start_d;
    end
  end
endmodule

// File: tb/tb_config_readback_tx.sv
// tb_config_readback_tx: directed frame, backpressure, snapshot, abort, reset and RD_LAT=3 checks
module tb_config_readback_tx;
  logic clk = 1'b0;
  logic rst, start, start3, abort;
  logic [7:0] cs;
  logic [4:0] al;
  logic [31:0] ps;
  logic busy_a, done_a, busy_b, done_b;
  int blen, cyc, errors, checks, n;
  int cnt_a, cnt_b, viol, unstable, dn_a, dn_b;
  int first_a, last_a, done_cyc_a, first_b, last_b;
  logic [7:0] held_a, pa, pb0, pb1, pb2;
  logic [7:0] expv [262];
  logic [7:0] rx_a[$];
  logic [7:0] rx_b[$];

  config_readback_tx_if #(.ADDR_W(5)) bus_a ();
  config_readback_tx_if #(.ADDR_W(5)) bus_b ();

  config_readback_tx #(.RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .channel_select(cs),
    .aline_select(al), .pulse_shape(ps), .bus(bus_a.master), .busy(busy_a), .done(done_a));

  config_readback_tx #(.RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .start(start3), .abort(abort), .channel_select(cs),
    .aline_select(al), .pulse_shape(ps), .bus(bus_b.master), .busy(busy_b), .done(done_b));

  always #5 clk = ~clk;

  // RAM returns {ch,addr} exactly RD_LAT cycles after a read strobe, 8'hEE otherwise
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pa <= bus_a.mem_rd_en ? {bus_a.mem_ch, bus_a.mem_addr} : 8'hEE;
    pb0 <= bus_b.mem_rd_en ? {bus_b.mem_ch, bus_b.mem_addr} : 8'hEE;
    pb1 <= pb0;
    pb2 <= pb1;
    cnt_a <= bus_a.tx_start ? blen : (cnt_a > 0 ? cnt_a - 1 : 0);
    cnt_b <= bus_b.tx_start ? blen : (cnt_b > 0 ? cnt_b - 1 : 0);
  end
  assign bus_a.mem_data = pa;
  assign bus_b.mem_data = pb2;
  assign bus_a.tx_busy = cnt_a != 0;
  assign bus_b.tx_busy = cnt_b != 0;

  always @(negedge clk) begin
    if (bus_a.tx_start) begin
      rx_a.push_back(bus_a.tx_data);
      if (rx_a.size() == 1) first_a = cyc;
      last_a = cyc;
      held_a = bus_a.tx_data;
      if (bus_a.tx_busy) viol++;
    end
    if (bus_a.tx_busy && bus_a.tx_data !== held_a) unstable++;
    if (done_a) begin
      dn_a++;
      done_cyc_a = cyc;
    end
    if (bus_b.tx_start) begin
      rx_b.push_back(bus_b.tx_data);
      if (rx_b.size() == 1) first_b = cyc;
      last_b = cyc;
      if (bus_b.tx_busy) viol++;
    end
    if (done_b) dn_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] q[$]);
    int bad = -1;
    check({tag, "_len"}, q.size(), 262);
    for (int i = 0; i < q.size() && i < 262; i++)
      if (bad < 0 && q[i] !== expv[i]) bad = i;
    check({tag, "_first_bad_idx"}, bad, -1);
  endtask

  task automatic pulse(input bit b);
    @(negedge clk);
    if (b) start3 = 1'b1;
    else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit b, input int budget);
    int d0 = b ? dn_b : dn_a;
    int k = 0;
    while ((b ? dn_b : dn_a) == d0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    check({tag, "_done_seen"}, (b ? dn_b : dn_a) != d0, 1);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    start3 = 1'b0;
    abort = 1'b0;
    cs = 8'hA5;
    al = 5'h13;
    ps = 32'h12345678;
    blen = 0;
    expv[0] = 8'hD4;
    expv[1] = 8'hB3;
    expv[2] = 8'h12;
    expv[3] = 8'h34;
    expv[4] = 8'h56;
    expv[5] = 8'h78;
    for (int i = 6; i < 262; i++) expv[i] = 8'(i - 6);
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_tx_start", bus_a.tx_start, 0);
    check("rst_rd_en", bus_a.mem_rd_en, 0);
    check("rst_done", done_a, 0);
    check("rst_tx_data", bus_a.tx_data, 0);
    check("rst_mem_sel", {bus_a.mem_ch, bus_a.mem_addr}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_no_tx", rx_a.size(), 0);

    rx_a.delete();
    pulse(0);
    wait_done("s1", 0, 5000);
    check_frame("s1", rx_a);
    check("s1_done_lat", done_cyc_a - last_a, 2);
    check("s1_tput", (last_a - first_a) <= 261 * 5, 1);
    repeat (5) @(negedge clk);
    check("s1_done_once", dn_a, 1);
    check("s1_idle", busy_a, 0);

    blen = 100;
    rx_a.delete();
    pulse(0);
    wait_done("s2", 0, 40000);
    check_frame("s2", rx_a);
    check("s2_start_while_busy", viol, 0);
    check("s2_tx_data_unstable", unstable, 0);
    check("s2_done_lat", done_cyc_a - last_a, 102);
    blen = 0;
    repeat (110) @(negedge clk);

    rx_a.delete();
    pulse(0);
    cs = 8'h00;
    al = 5'h00;
    ps = 32'h0;
    n = 0;
    while (rx_a.size() < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    pulse(0);
    wait_done("s3", 0, 5000);
    check_frame("s3", rx_a);
    repeat (20) @(negedge clk);
    check("s3_no_extra_frame", rx_a.size(), 262);
    check("s3_idle", busy_a, 0);
    cs = 8'hA5;
    al = 5'h13;
    ps = 32'h12345678;

    rx_a.delete();
    n = dn_a;
    pulse(0);
    while (!(bus_a.mem_rd_en && bus_a.mem_ch == 3'd1 && bus_a.mem_addr == 5'd2) && rx_a.size() < 262) @(negedge clk);
    check("s4_reached_idx40", rx_a.size(), 40);
    abort = 1'b1;
    @(posedge clk);
    #1;
    check("s4_abort_busy", busy_a, 0);
    check("s4_abort_rd_en", bus_a.mem_rd_en, 0);
    check("s4_abort_tx_start", bus_a.tx_start, 0);
    @(negedge clk);
    abort = 1'b0;
    repeat (50) @(negedge clk);
    check("s4_no_more_tx", rx_a.size(), 40);
    check("s4_no_done", dn_a, n);
    rx_a.delete();
    pulse(0);
    wait_done("s4_restart", 0, 5000);
    check_frame("s4_restart", rx_a);

    rx_a.delete();
    pulse(0);
    n = 0;
    while (!(bus_a.tx_start && bus_a.tx_data == 8'h03) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("s5_reached_byte9", bus_a.tx_start, 1);
    #1 rst = 1'b0;
    #1;
    check("s5_rst_busy", busy_a, 0);
    check("s5_rst_tx_start", bus_a.tx_start, 0);
    check("s5_rst_rd_en", bus_a.mem_rd_en, 0);
    check("s5_rst_done", done_a, 0);
    check("s5_rst_tx_data", bus_a.tx_data, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("s5_quiet_after_rst", rx_a.size(), 10);
    check("s5_idle", busy_a, 0);
    rx_a.delete();
    pulse(0);
    wait_done("s5_restart", 0, 5000);
    check_frame("s5_restart", rx_a);

    rx_b.delete();
    pulse(1);
    wait_done("s6", 1, 8000);
    check_frame("s6", rx_b);
    check("s6_tput", (last_b - first_b) <= 261 * 7, 1);
    check("s6_start_while_busy", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
